mem_access_ctrl: RTL and testbench

Memory-side initiator for the multicycle MIPS core. It accepts instruction-fetch and load/store requests from the datapath over two independent request ports and arbitrates between them. It drives the address, write-data and write-enable ports of the single-port unified instruction/data memory and captures the memory's combinational read data into a response register. It also rejects misaligned and out-of-range accesses before they reach the memory array.

---
 rtl/mem_access_ctrl.sv | 70 +++++++
 tb/tb_mem_access_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: arbitrates fetch/data requests onto a single-port memory with alignment and range checks
module mem_access_ctrl #(
    parameter int DEPTH = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_instr,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t      state, state_nx;
    logic        last_grant, gnt, we, err, pick_d, req_err, live;
    logic [31:0] addr, wdata, req_addr;
    // arbitration, request checking, next state and memory-side outputs
    always_comb begin
        pick_d           = d_req && (!if_req || !last_grant);
        req_addr         = pick_d ? d_addr : if_addr;
        req_err          = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(DEPTH));
        state_nx         = state == IDLE ? ((if_req || d_req) ? ACCESS : IDLE) :
                           state == ACCESS ? RESP : IDLE;
        live             = state == ACCESS && !err && !reset;
        mem_address      = live ? addr : 32'h0;
        mem_write_enable = live && we;
        mem_write_data   = (live && we) ? wdata : 32'h0;
        if_done          = state == RESP && !gnt;
        d_done           = state == RESP && gnt;
        if_err           = if_done && err;
        d_err            = d_done && err;
    end
    // state register, grant latch and read-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            gnt        <= 1'b0;
            we         <= 1'b0;
            err        <= 1'b0;
            addr       <= 32'h0;
            wdata      <= 32'h0;
            if_instr   <= 32'h0;
            d_rdata    <= 32'h0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (if_req || d_req)) begin
                gnt   <= pick_d;
                addr  <= req_addr;
                we    <= pick_d && d_we;
                wdata <= pick_d ? d_wdata : 32'h0;
                err   <= req_err;
            end
            if (state == ACCESS && !gnt) if_instr <= err ? 32'h0 : mem_data;
            if (state == ACCESS && gnt && !we) d_rdata <= err ? 32'h0 : mem_data;
            if (state == RESP) last_grant <= gnt;
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vector bench for mem_access_ctrl with a behavioural memory
module tb_mem_access_ctrl;
    logic        clk = 1'b0, reset = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
    logic        if_done, if_err, d_done, d_err, mem_write_enable;
    logic [31:0] if_instr, d_rdata, mem_address, mem_write_data, mem_data;
    logic [31:0] mem [0:4095];
    int          errors = 0, checks = 0;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        bit          exp_err;
        int          exp_we;
    } vec_t;
    vec_t vecs[12];

    mem_access_ctrl #(.DEPTH(4096)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_instr(if_instr), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    assign mem_data = (mem_address < 32'd4096) ? mem[mem_address[11:0]] : 32'h0;

    always @(posedge clk)
        if (mem_write_enable && mem_address < 32'd4096) mem[mem_address[11:0]] <= mem_write_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, " ctl"}, {27'h0, if_done, d_done, if_err, d_err, mem_write_enable}, 32'h0);
        check({name, " if_instr"}, if_instr, 32'h0);
        check({name, " d_rdata"}, d_rdata, 32'h0);
        check({name, " mem_address"}, mem_address, 32'h0);
        check({name, " mem_write_data"}, mem_write_data, 32'h0);
    endtask

    task automatic run(input vec_t v, input int idx);
        int          done_at = -1, wecnt = 0;
        logic [31:0] acc_addr = 32'hffff_ffff, got_data = 32'h0;
        logic        got_err = 1'b0, got_port = 1'b0;
        string       n;
        n = $sformatf("vec%0d", idx);
        @(negedge clk);
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        for (int c = 1; c <= 8 && done_at < 0; c++) begin
            @(negedge clk);
            if (mem_write_enable) wecnt++;
            if (c == 1) acc_addr = mem_address;
            if (if_done || d_done) begin
                done_at  = c;
                got_port = d_done;
                got_err  = d_done ? d_err : if_err;
                got_data = v.is_d ? d_rdata : if_instr;
            end
        end
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        check({n, " latency"}, 32'(done_at), 32'd2);
        check({n, " port"}, {31'h0, got_port}, {31'h0, v.is_d});
        check({n, " err"}, {31'h0, got_err}, {31'h0, v.exp_err});
        check({n, " data"}, got_data, v.exp_data);
        check({n, " we_cycles"}, 32'(wecnt), 32'(v.exp_we));
        check({n, " access_addr"}, acc_addr, v.exp_err ? 32'h0 : v.addr);
    endtask

    initial begin
        string order;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[8]    = 32'h1111_2222;
        mem[40]   = 32'h4040_4040;
        mem[128]  = 32'h0022_1820;
        mem[132]  = 32'h3333_4444;
        mem[4092] = 32'hCAFE_F00D;

        vecs[0]  = '{1'b0, 1'b0, 32'd128,        32'h0,         32'h0022_1820, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b1, 32'd24,         32'hDEAD_BEEF, 32'h1111_2222, 1'b0, 1};
        vecs[2]  = '{1'b1, 1'b0, 32'd24,         32'h0,         32'hDEAD_BEEF, 1'b0, 0};
        vecs[3]  = '{1'b1, 1'b1, 32'd6,          32'h0000_0055, 32'hDEAD_BEEF, 1'b1, 0};
        vecs[4]  = '{1'b0, 1'b0, 32'd4096,       32'h0,         32'h0,         1'b1, 0};
        vecs[5]  = '{1'b1, 1'b0, 32'd4092,       32'h0,         32'hCAFE_F00D, 1'b0, 0};
        vecs[6]  = '{1'b1, 1'b1, 32'd4092,       32'h1234_5678, 32'hCAFE_F00D, 1'b0, 1};
        vecs[7]  = '{1'b1, 1'b0, 32'd4092,       32'h0,         32'h1234_5678, 1'b0, 0};
        vecs[8]  = '{1'b1, 1'b0, 32'd4096,       32'h0,         32'h0,         1'b1, 0};
        vecs[9]  = '{1'b0, 1'b0, 32'd2,          32'h0,         32'h0,         1'b1, 0};
        vecs[10] = '{1'b0, 1'b0, 32'd132,        32'h0,         32'h3333_4444, 1'b0, 0};
        vecs[11] = '{1'b1, 1'b0, 32'h8000_0000,  32'h0,         32'h0,         1'b1, 0};

        if_req = 1'b1; if_addr = 32'd132; d_req = 1'b1; d_addr = 32'd8;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        order = "";
        for (int c = 0; c < 30 && order.len() < 4; c++) begin
            @(negedge clk);
            if (d_done) begin
                order = {order, "D"};
                check("tie d_rdata", d_rdata, 32'h1111_2222);
            end
            if (if_done) begin
                order = {order, "F"};
                check("tie if_instr", if_instr, 32'h3333_4444);
            end
        end
        checks++;
        if (order != "DFDF") begin
            errors++;
            $display("FAIL tie order: got %s expected DFDF", order);
        end
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run(vecs[i], i);
        check("mem[24]", mem[24], 32'hDEAD_BEEF);
        check("mem[4]", mem[4], 32'h0);

        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd40; d_wdata = 32'h0000_0099;
        @(negedge clk);
        check("pre-reset we", {31'h0, mem_write_enable}, 32'h1);
        reset = 1'b1;
        #1;
        check("reset-access we", {31'h0, mem_write_enable}, 32'h0);
        @(negedge clk);
        check_zero("after reset-access");
        check("mem[40]", mem[40], 32'h4040_4040);
        d_req = 1'b0; d_we = 1'b0; reset = 1'b0;

        @(negedge clk);
        if_req = 1'b1; if_addr = 32'd128;
        repeat (2) @(negedge clk);
        check("resp if_done", {31'h0, if_done}, 32'h1);
        reset = 1'b1;
        #1;
        check("reset-resp if_done", {31'h0, if_done}, 32'h1);
        @(negedge clk);
        check_zero("after reset-resp");
        if_req = 1'b0; reset = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
